// File: rtl/poets_stream_framer_if.sv
// Host word link plus Avalon-ST output bundle for poets_stream_framer.
// master: the framer side; slave: the host/sink environment side.
interface poets_stream_framer_if;
  logic        host_in_valid;
  logic [31:0] host_in_data;
  logic        host_in_ready;
  logic        stream_out_valid;
  logic [31:0] stream_out_data;
  logic        stream_out_startofpacket;
  logic        stream_out_endofpacket;
  logic [1:0]  stream_out_empty;
  logic        stream_out_ready;

  modport master (
    input  host_in_valid, host_in_data, stream_out_ready,
    output host_in_ready, stream_out_valid, stream_out_data,
           stream_out_startofpacket, stream_out_endofpacket, stream_out_empty
  );

  modport slave (
    output host_in_valid, host_in_data, stream_out_ready,
    input  host_in_ready, stream_out_valid, stream_out_data,
           stream_out_startofpacket, stream_out_endofpacket, stream_out_empty
  );
endinterface

// File: rtl/poets_stream_framer.sv
// Frames a length-prefixed host word stream into Avalon-ST packets for the
// POETS stream_in port; malformed headers are swallowed and counted.
module poets_stream_framer #(
  parameter int unsigned MAX_BYTES = 1024
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  poets_stream_framer_if.master bus,
  output logic [15:0]          err_count,
  output logic                 busy
);

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_BYTES);

  state_t      state, state_next;
  logic [16:0] remaining;
  logic [1:0]  tail;
  logic        first;

  logic [15:0] len;
  logic [16:0] words;
  logic        hdr_zero, hdr_big;
  logic        in_ready, accept, last_word, load;
  logic [1:0]  eop_empty;
  logic        unused_hdr_hi;

  assign unused_hdr_hi = ^bus.host_in_data[31:16];

  always_comb begin
    len      = bus.host_in_data[15:0];
    words    = ({1'b0, len} + 17'd3) >> 2;
    hdr_zero = (len == 16'd0);
    hdr_big  = ({1'b0, len} > MAX_LEN);
  end

  // In HDR the header is taken regardless of the output register, so a new
  // header may overlap the previous packet's eop word still waiting there.
  always_comb begin
    in_ready = 1'b1;
    if (state == PAYLOAD)
      in_ready = !bus.stream_out_valid || bus.stream_out_ready;
  end

  assign bus.host_in_ready = in_ready;
  assign accept    = bus.host_in_valid && in_ready;
  assign last_word = (remaining == 17'd1);
  assign load      = (state == PAYLOAD) && accept;

  always_comb begin
    case (tail)
      2'd1:    eop_empty = 2'd3;
      2'd2:    eop_empty = 2'd2;
      2'd3:    eop_empty = 2'd1;
      default: eop_empty = 2'd0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= HDR;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (accept) begin
          if (hdr_big)        state_next = DROP;
          else if (!hdr_zero) state_next = PAYLOAD;
        end
      end
      PAYLOAD, DROP: begin
        if (accept && last_word) state_next = HDR;
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      remaining                    <= '0;
      tail                         <= '0;
      first                        <= 1'b0;
      err_count                    <= '0;
      bus.stream_out_valid         <= 1'b0;
      bus.stream_out_data          <= '0;
      bus.stream_out_startofpacket <= 1'b0;
      bus.stream_out_endofpacket   <= 1'b0;
      bus.stream_out_empty         <= '0;
    end else begin
      if (state == HDR && accept) begin
        if (!hdr_zero) remaining <= words;
        if (!hdr_zero && !hdr_big) begin
          tail  <= len[1:0];
          first <= 1'b1;
        end
        if ((hdr_zero || hdr_big) && err_count != '1)
          err_count <= err_count + 16'd1;
      end

      if (state != HDR && accept)
        remaining <= remaining - 17'd1;

      if (load) begin
        first                        <= 1'b0;
        bus.stream_out_valid         <= 1'b1;
        bus.stream_out_data          <= bus.host_in_data;
        bus.stream_out_startofpacket <= first;
        bus.stream_out_endofpacket   <= last_word;
        bus.stream_out_empty         <= last_word ? eop_empty : 2'd0;
      end else if (bus.stream_out_valid && bus.stream_out_ready) begin
        bus.stream_out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != HDR) || bus.stream_out_valid;

endmodule

// File: doc/poets_stream_framer.md
# poets_stream_framer

Upstream framing stage for the POETS streaming system. It accepts an unframed 32-bit word stream from the host link, where each packet starts with a header word giving its byte length. It emits Avalon-ST packets (sop/eop/empty) that drive the system's `stream_in_*` port directly. Malformed headers are dropped and counted, so the system never sees a bad frame.

## Interface
- `MAX_BYTES`, default 1024: largest legal packet length in bytes; legal range 1..65535.
- `clk_clk`  in  1  sole clock.
- `reset_reset`  in  1  synchronous, active-high reset.
- `host_in_valid`  in  1  host word valid.
- `host_in_data`  in  32  host word (header or payload).
- `host_in_ready`  out  1  host word accepted when valid && ready.
- `stream_out_valid`  out  1  Avalon-ST valid, to system `stream_in_valid`.
- `stream_out_data`  out  32  payload word; first byte in [31:24].
- `stream_out_startofpacket`  out  1  first payload word of packet.
- `stream_out_endofpacket`  out  1  last payload word of packet.
- `stream_out_empty`  out  2  unused bytes in the eop word; 0 when eop is low.
- `stream_out_ready`  in  1  downstream ready; zero ready latency.
- `err_count`  out  16  count of dropped headers; saturates at 0xFFFF.
- `busy`  out  1  high when state is not HDR or `stream_out_valid` is high.

## Operation
- Header word: `len = host_in_data[15:0]`. Bits [31:16] are ignored.
- Word count: `words = (len + 3) >> 2`, computed 17 bits wide.
- Tail: `tail = len[1:0]`. Required empty: tail 0→0, 1→3, 2→2, 3→1.
- **HDR**
  - `host_in_ready = 1`, independent of the output register.
  - On accept with 1 ≤ len ≤ MAX_BYTES: load `remaining = words`, latch `tail`, set `first = 1`, go to PAYLOAD.
  - On accept with len = 0: stay in HDR; `err_count += 1` (saturating).
  - On accept with len > MAX_BYTES: load `remaining = words`, go to DROP; `err_count += 1` (saturating).
- **PAYLOAD**
  - `host_in_ready = !stream_out_valid || stream_out_ready`.
  - Each accepted word loads the output register with:
    - data = the word
    - sop = `first`
    - eop = (`remaining == 1`)
    - empty = eop ? map(tail) : 0
  - On each accept, `first` clears and `remaining` decrements.
  - When `remaining == 1` is accepted, go to HDR.
  - A single-word packet carries sop and eop together.
- **DROP**
  - `host_in_ready = 1`.
  - Accepted words are discarded and `remaining` decrements.
  - When `remaining == 1` is accepted, go to HDR. Nothing is emitted.
- **Output register** (one stage)
  - Loads on a PAYLOAD accept.
  - Clears `stream_out_valid` when (valid && ready) and there is no simultaneous load.
  - A simultaneous drain and load keeps valid high with the new word.
  - Contents are held stable while valid && !ready.
- A header may be accepted while the previous packet's last word still waits in the output register. That word's fields must not change.

## Timing
- Reset (synchronous, active-high), applied in any state including mid-packet:
  - state=HDR; `stream_out_valid`, sop, eop = 0; empty = 0; data = 0; `err_count` = 0; `busy` = 0; `host_in_ready` = 1 from the first cycle after reset.
  - Any partial packet is lost, with no eop emitted.
- Latency: a payload word accepted at edge N is presented with `stream_out_valid = 1` after edge N, i.e. in cycle N+1.
- Throughput: one payload word per cycle with ready held high. Each header costs one bubble cycle.
- No combinational path from `host_in_valid` to `stream_out_*`. `host_in_ready` depends combinationally on `stream_out_ready` in PAYLOAD only.
- `err_count` updates in the cycle after the header is accepted.

## Test plan
- **Basic packet.** Header 0x0000_000A then words A0..A2, ready=1. Expect:
  - 3 output words: sop on A0, eop on A2, empty=2 on A2.
  - First output in the cycle after A0 is accepted.
  - No gaps between payload words.
- **Single word and tails.** Headers with len=1, 4, 5, 8. Expect:
  - len=1: one word with sop=eop=1, empty=3.
  - len=4: empty=0.
  - len=5: 2 words, empty=3.
  - len=8: 2 words, empty=0.
- **Backpressure.** len=16; `stream_out_ready` toggles 1,0,0,1 repeating. Expect:
  - Output data and flags stable while stalled.
  - No word lost or duplicated; order preserved.
  - `host_in_ready` low whenever the register is full and ready=0.
- **Bad headers.** len=0, then len=MAX_BYTES+1 followed by 257 words, then a valid len=4 packet. Expect:
  - `err_count` = 2.
  - The 257 words are consumed with nothing emitted.
  - The len=4 packet is emitted intact with sop=eop=1.
- **Back-to-back.** Two len=4 packets with eop held in the register (ready=0) while the second header arrives. Expect:
  - Header accepted while the first packet's word waits.
  - First packet's word unchanged until drained.
  - Second packet follows correctly.
- **Reset mid-packet.** len=32, accept 3 words, then assert `reset_reset` for 1 cycle. Expect:
  - `stream_out_valid` = 0, `err_count` = 0.
  - The next header is parsed as a fresh header, not as payload.
